// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB encodings for the data-phase response path. It holds the HTRANS
// and HRESP encodings and the default-slave state type.
// ---------------------------------------------------------------------------
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// Default slave for the AHB response mux. It produces the two-cycle ERROR
// response (ERR1: HREADY=0/HRESP=1, then ERR2: HREADY=1/HRESP=1) for armed
// transfers. When AHB_RESP_MUX_TIMEOUT_EN is defined it also contains the
// stall watchdog that aborts a slave which holds HREADY low too long.
//
// state   | meaning
// --------+-------------------------------------------------------------
// DS_IDLE | no error in progress; HREADY=1, HRESP=OKAY
// DS_ERR1 | first ERROR cycle; HREADY=0, HRESP=ERROR
// DS_ERR2 | second ERROR cycle; HREADY=1, HRESP=ERROR, can re-arm
//
// Ports:
//   HCLK, HRESETn : bus clock, async active-low reset
//   arm           : the address phase on the bus needs an ERROR response
//   accept        : the address phase is accepted on this edge (bus HREADY)
//   force_err     : the selected slave is holding HREADY low this cycle; a
//                   run of TIMEOUT_CYCLES of these forces an ERROR (watchdog)
//   ds_ready      : default-slave HREADY (registered)
//   ds_resp       : default-slave HRESP (registered)
//   abort         : watchdog fires on this edge; the top drops its select
//   timeout_irq   : sticky watchdog flag
// ---------------------------------------------------------------------------
module ahb_default_slave #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic arm,
   input  logic accept,
   input  logic force_err,
   output logic ds_ready,
   output logic ds_resp,
   output logic abort,
   output logic timeout_irq
);

   import ahb_pkg::*;

   ds_state_t state;
   logic      wd_hit;
   logic      start_err;

`ifdef AHB_RESP_MUX_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wd_cnt;
   logic          irq_q;

   // Fire on the edge that would complete the TIMEOUT_CYCLES-th stall cycle,
   // so the ERROR starts right after exactly that many stalled cycles.
   assign wd_hit = force_err && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wd_cnt <= '0;
         irq_q  <= 1'b0;
      end else if (wd_hit) begin
         wd_cnt <= '0;
         irq_q  <= 1'b1;
      end else if (force_err) begin
         wd_cnt <= wd_cnt + CW'(1);
      end else begin
         wd_cnt <= '0;
      end
   end

   assign timeout_irq = irq_q;
`else
   logic unused_force_err;
   localparam int unused_timeout = TIMEOUT_CYCLES;

   assign unused_force_err = force_err;
   assign wd_hit           = 1'b0;
   assign timeout_irq      = 1'b0;
`endif

   assign abort     = wd_hit;
   assign start_err = (accept && arm) || wd_hit;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= DS_IDLE;
         ds_ready <= 1'b1;
         ds_resp  <= HRESP_OKAY;
      end else begin
         case (state)
            DS_ERR1: begin
               state    <= DS_ERR2;
               ds_ready <= 1'b1;
               ds_resp  <= HRESP_ERROR;
            end
            default: begin
               // IDLE and ERR2 behave alike: ERR2 has HREADY=1, so a new
               // armed transfer accepted there chains straight into ERR1.
               if (start_err) begin
                  state    <= DS_ERR1;
                  ds_ready <= 1'b0;
                  ds_resp  <= HRESP_ERROR;
               end else begin
                  state    <= DS_IDLE;
                  ds_ready <= 1'b1;
                  ds_resp  <= HRESP_OKAY;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/ahb_resp_mux.sv
// ---------------------------------------------------------------------------
// ahb_resp_mux
// AHB data-phase response multiplexer. It registers the decoder's one-hot
// slave select on each accepted address phase and steers that slave's
// HRDATA/HREADYOUT/HRESP to the master during the data phase. Unmapped or
// multi-selected active transfers go to the internal default slave, which
// answers with a two-cycle ERROR.
//
// Build option: define AHB_RESP_MUX_TIMEOUT_EN to include the stall
// watchdog (TIMEOUT_CYCLES); without it TIMEOUT_IRQ is tied low.
//
// Ports:
//   HCLK, HRESETn : bus clock, async active-low reset
//   HSELx         : address-phase one-hot slave select
//   HERROR        : address-phase unmapped-address flag
//   HTRANS        : master transfer type
//   HRDATA_S      : packed slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   HREADYOUT_S   : per-slave ready
//   HRESP_S       : per-slave response
//   HRDATA        : muxed read data
//   HREADY        : muxed ready to master and slaves
//   HRESP         : muxed response
//   TIMEOUT_IRQ   : sticky watchdog flag
// ---------------------------------------------------------------------------
module ahb_resp_mux #(
   parameter int NUM_SLAVES     = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             HCLK,
   input  logic                             HRESETn,
   input  logic [NUM_SLAVES-1:0]            HSELx,
   input  logic                             HERROR,
   input  logic [1:0]                       HTRANS,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
   input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
   input  logic [NUM_SLAVES-1:0]            HRESP_S,
   output logic [DATA_WIDTH-1:0]            HRDATA,
   output logic                             HREADY,
   output logic                             HRESP,
   output logic                             TIMEOUT_IRQ
);

   import ahb_pkg::*;

   logic [NUM_SLAVES-1:0] sel_q;
   logic                  addr_active;
   logic                  sel_onehot;
   logic                  arm;
   logic                  slave_active;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_ready;
   logic                  sel_resp;
   logic                  ds_ready;
   logic                  ds_resp;
   logic                  abort;

   assign addr_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
   assign sel_onehot  = $onehot(HSELx);
   assign arm         = addr_active && (HERROR || !sel_onehot);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sel_q <= '0;
      end else if (abort) begin
         sel_q <= '0;
      end else if (HREADY) begin
         sel_q <= (addr_active && sel_onehot && !HERROR) ? HSELx : '0;
      end
   end

   // sel_q is one-hot or zero, so OR-reduction is a plain mux and yields
   // zero data when nothing is selected.
   always_comb begin
      sel_data  = '0;
      sel_ready = 1'b0;
      sel_resp  = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q[i]) begin
            sel_data  = sel_data | HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
            sel_ready = sel_ready | HREADYOUT_S[i];
            sel_resp  = sel_resp | HRESP_S[i];
         end
      end
   end

   assign slave_active = |sel_q;

   assign HRDATA = sel_data;
   assign HREADY = slave_active ? sel_ready : ds_ready;
   assign HRESP  = slave_active ? sel_resp  : ds_resp;

   ahb_default_slave #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_default_slave (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .arm         (arm),
      .accept      (HREADY),
      .force_err   (slave_active && !sel_ready),
      .ds_ready    (ds_ready),
      .ds_resp     (ds_resp),
      .abort       (abort),
      .timeout_irq (TIMEOUT_IRQ)
   );

endmodule

// File: tb/tb_ahb_resp_mux.sv
// ---------------------------------------------------------------------------
// tb_ahb_resp_mux
// Self-checking bench for ahb_resp_mux: a table of single address phases,
// followed by hand-written multi-cycle sequences (stall, back-to-back errors,
// error then mapped transfer, reset in ERR1, watchdog or unbounded stall).
// ---------------------------------------------------------------------------
module tb_ahb_resp_mux;

   import ahb_pkg::*;

   localparam int NS = 4;
   localparam int DW = 32;

   logic             HCLK;
   logic             HRESETn;
   logic [NS-1:0]    HSELx;
   logic             HERROR;
   logic [1:0]       HTRANS;
   logic [NS*DW-1:0] HRDATA_S;
   logic [NS-1:0]    HREADYOUT_S;
   logic [NS-1:0]    HRESP_S;
   logic [DW-1:0]    HRDATA;
   logic             HREADY;
   logic             HRESP;
   logic             TIMEOUT_IRQ;

   ahb_resp_mux #(
      .NUM_SLAVES     (NS),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .HSELx       (HSELx),
      .HERROR      (HERROR),
      .HTRANS      (HTRANS),
      .HRDATA_S    (HRDATA_S),
      .HREADYOUT_S (HREADYOUT_S),
      .HRESP_S     (HRESP_S),
      .HRDATA      (HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .TIMEOUT_IRQ (TIMEOUT_IRQ)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct packed {
      logic          rdy;
      logic          resp;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct {
      logic [1:0]    trans;
      logic [NS-1:0] sel;
      logic          err;
      int            idx;     // expected slave, -1 for none
      logic          exp_err; // expect two-cycle ERROR
   } vec_t;

   exp_t          q[$];
   vec_t          vt[12];
   logic [DW-1:0] slv_data[NS];
   int            n_vec = 0;
   int            n_err = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic step_check(input string name);
      exp_t e;
      @(negedge HCLK);
      n_vec++;
      if (q.size() == 0) begin
         n_err++;
         $display("FAIL %s: scoreboard empty, got rdy=%b resp=%b data=%h", name, HREADY, HRESP, HRDATA);
      end else begin
         e = q.pop_front();
         if ({HREADY, HRESP, HRDATA} !== {e.rdy, e.resp, e.data}) begin
            n_err++;
            $display("FAIL %s: got rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
                     name, HREADY, HRESP, HRDATA, e.rdy, e.resp, e.data);
         end
      end
      @(posedge HCLK);
      #1;
   endtask

   task automatic drain(input string name);
      while (q.size() != 0) step_check(name);
   endtask

   task automatic push(input logic rdy, input logic resp, input logic [DW-1:0] data);
      exp_t e;
      e.rdy  = rdy;
      e.resp = resp;
      e.data = data;
      q.push_back(e);
   endtask

   task automatic push_err2();
      push(1'b0, HRESP_ERROR, '0);
      push(1'b1, HRESP_ERROR, '0);
   endtask

   task automatic drive_idle();
      HTRANS = HTRANS_IDLE;
      HSELx  = '0;
      HERROR = 1'b0;
   endtask

   task automatic drive_addr(input logic [1:0] t, input logic [NS-1:0] s, input logic e);
      HTRANS = t;
      HSELx  = s;
      HERROR = e;
   endtask

   initial begin
      #100000;
      $display("FAIL sim_timeout: run still active at %0t, limit 100000", $time);
      $fatal(1);
   end

   initial begin
      slv_data[0] = 32'h1111_0001;
      slv_data[1] = 32'h2222_0002;
      slv_data[2] = 32'hDEAD_BEEF;
      slv_data[3] = 32'h4444_0004;
      for (int i = 0; i < NS; i++) HRDATA_S[i*DW +: DW] = slv_data[i];
      HREADYOUT_S = 4'hF;
      HRESP_S     = 4'b1000;
      HRESETn     = 1'b0;
      drive_idle();

      vt[0]  = '{HTRANS_NONSEQ, 4'b0001, 1'b0,  0, 1'b0};
      vt[1]  = '{HTRANS_SEQ,    4'b0010, 1'b0,  1, 1'b0};
      vt[2]  = '{HTRANS_NONSEQ, 4'b0100, 1'b0,  2, 1'b0};
      vt[3]  = '{HTRANS_NONSEQ, 4'b1000, 1'b0,  3, 1'b0};
      vt[4]  = '{HTRANS_NONSEQ, 4'b0000, 1'b0, -1, 1'b1};
      vt[5]  = '{HTRANS_NONSEQ, 4'b0011, 1'b0, -1, 1'b1};
      vt[6]  = '{HTRANS_NONSEQ, 4'b0100, 1'b1, -1, 1'b1};
      vt[7]  = '{HTRANS_IDLE,   4'b0100, 1'b0, -1, 1'b0};
      vt[8]  = '{HTRANS_BUSY,   4'b0000, 1'b1, -1, 1'b0};
      vt[9]  = '{HTRANS_IDLE,   4'b0000, 1'b1, -1, 1'b0};
      vt[10] = '{HTRANS_SEQ,    4'b1111, 1'b0, -1, 1'b1};
      vt[11] = '{HTRANS_NONSEQ, 4'b1000, 1'b0,  3, 1'b0};

      // reset values, during and after reset
      #12;
      chk("rst_hready", DW'(HREADY), DW'(1));
      chk("rst_hresp",  DW'(HRESP),  DW'(HRESP_OKAY));
      chk("rst_hrdata", HRDATA,      '0);
      chk("rst_irq",    DW'(TIMEOUT_IRQ), DW'(0));
      #10;
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;
      chk("post_rst_hready", DW'(HREADY), DW'(1));
      chk("post_rst_hresp",  DW'(HRESP),  DW'(HRESP_OKAY));

      // table: one address phase each, then the data phase(s) and one OKAY idle cycle
      for (int i = 0; i < 12; i++) begin
         drive_addr(vt[i].trans, vt[i].sel, vt[i].err);
         if (vt[i].exp_err) push_err2();
         else if (vt[i].idx >= 0) push(1'b1, HRESP_S[vt[i].idx], slv_data[vt[i].idx]);
         else push(1'b1, HRESP_OKAY, '0);
         push(1'b1, HRESP_OKAY, '0);
         @(posedge HCLK);
         #1;
         drive_idle();
         drain($sformatf("vec%0d", i));
      end

      // slave 2 stalls for three cycles, then completes
      drive_addr(HTRANS_NONSEQ, 4'b0100, 1'b0);
      @(posedge HCLK);
      #1;
      drive_idle();
      HREADYOUT_S[2] = 1'b0;
      repeat (3) push(1'b0, HRESP_OKAY, 32'hDEAD_BEEF);
      push(1'b1, HRESP_OKAY, 32'hDEAD_BEEF);
      push(1'b1, HRESP_OKAY, '0);
      for (int k = 0; k < 3; k++) step_check("stall");
      HREADYOUT_S[2] = 1'b1;
      drain("stall_done");

      // multi-hot error, then HERROR transfer held through ERR1 and accepted in ERR2
      drive_addr(HTRANS_NONSEQ, 4'b0011, 1'b0);
      @(posedge HCLK);
      #1;
      drive_addr(HTRANS_NONSEQ, 4'b0000, 1'b1);
      push_err2();
      push_err2();
      push(1'b1, HRESP_OKAY, '0);
      step_check("b2b");
      step_check("b2b");
      drive_idle();
      drain("b2b");

      // error, then a mapped transfer accepted in ERR2 goes to its slave
      drive_addr(HTRANS_NONSEQ, 4'b0000, 1'b1);
      @(posedge HCLK);
      #1;
      drive_addr(HTRANS_NONSEQ, 4'b0010, 1'b0);
      push_err2();
      push(1'b1, HRESP_OKAY, slv_data[1]);
      push(1'b1, HRESP_OKAY, '0);
      step_check("err_then_map");
      step_check("err_then_map");
      drive_idle();
      drain("err_then_map");

      // reset asserted during ERR1 clears outputs at once
      drive_addr(HTRANS_NONSEQ, 4'b0000, 1'b1);
      @(posedge HCLK);
      #1;
      drive_idle();
      @(negedge HCLK);
      chk("err1_hready", DW'(HREADY), DW'(0));
      chk("err1_hresp",  DW'(HRESP),  DW'(HRESP_ERROR));
      #1;
      HRESETn = 1'b0;
      #1;
      chk("rst_err1_hready", DW'(HREADY), DW'(1));
      chk("rst_err1_hresp",  DW'(HRESP),  DW'(HRESP_OKAY));
      #1;
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;
      push(1'b1, HRESP_OKAY, '0);
      push(1'b1, HRESP_OKAY, '0);
      drain("after_rst_err1");

`ifdef AHB_RESP_MUX_TIMEOUT_EN
      // slave 0 never ready: 16 stall cycles, then ERR1/ERR2, then OKAY
      HREADYOUT_S[0] = 1'b0;
      drive_addr(HTRANS_NONSEQ, 4'b0001, 1'b0);
      @(posedge HCLK);
      #1;
      drive_idle();
      repeat (16) push(1'b0, HRESP_OKAY, slv_data[0]);
      push_err2();
      push(1'b1, HRESP_OKAY, '0);
      drain("watchdog");
      chk("wd_irq_set", DW'(TIMEOUT_IRQ), DW'(1));
      HREADYOUT_S[0] = 1'b1;
      repeat (3) @(posedge HCLK);
      #1;
      chk("wd_irq_sticky", DW'(TIMEOUT_IRQ), DW'(1));
      #1;
      HRESETn = 1'b0;
      #1;
      chk("wd_irq_rst", DW'(TIMEOUT_IRQ), DW'(0));
      #1;
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;
`else
      // without the watchdog a stall is unbounded
      HREADYOUT_S[0] = 1'b0;
      drive_addr(HTRANS_NONSEQ, 4'b0001, 1'b0);
      @(posedge HCLK);
      #1;
      drive_idle();
      repeat (20) push(1'b0, HRESP_OKAY, slv_data[0]);
      for (int k = 0; k < 20; k++) step_check("long_stall");
      HREADYOUT_S[0] = 1'b1;
      push(1'b1, HRESP_OKAY, slv_data[0]);
      push(1'b1, HRESP_OKAY, '0);
      drain("long_stall_done");
      chk("no_wd_irq", DW'(TIMEOUT_IRQ), DW'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
